// File: rtl/jtag_host_seq.sv
// On-chip JTAG initiator: runs TLR / IR-shift / DR-shift / idle-clock commands against a TAP
// and returns the TDO bits captured during the shift phase.
module jtag_host_seq #(
  parameter int MaxLen = 64,
  parameter int ClkDiv = 4,
  localparam int LenW = $clog2(MaxLen + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [LenW-1:0]   cmd_len_i,
  input  logic [MaxLen-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              jtag_tck_o,
  output logic              jtag_tms_o,
  output logic              jtag_tdi_o,
  output logic              jtag_trst_no,
  input  logic              jtag_tdo_i
);

  localparam int BitW = LenW + 3;
  localparam int SelW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam int PhW  = (ClkDiv > 1) ? $clog2(2 * ClkDiv) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StResp} state_e;
  typedef enum logic [1:0] {
    OpTlr     = 2'd0,
    OpShiftIr = 2'd1,
    OpShiftDr = 2'd2,
    OpIdle    = 2'd3
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [LenW-1:0]     len_q, len_d;
  logic [MaxLen-1:0]   data_q, data_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [PhW-1:0]      phase_q, phase_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                trst_q, trst_d;
  logic [MaxLen-1:0]   rspData_q, rspData_d;
  logic                rspErr_q, rspErr_d;
  logic                readyEn_q, readyEn_d;

  op_e                 cmdOp;
  logic                lenBad;
  logic [BitW-1:0]     lastBit;

  // Number of TMS bits that walk Run-Test/Idle into Shift-IR / Shift-DR.
  function automatic int preBits(input op_e op);
    return (op == OpShiftIr) ? 4 : 3;
  endfunction

  function automatic logic [BitW-1:0] totalBits(input op_e op, input logic [LenW-1:0] len);
    logic [BitW-1:0] n;
    n = BitW'(len);
    case (op)
      OpTlr:     return BitW'(6);
      OpShiftIr: return n + BitW'(6);
      OpShiftDr: return n + BitW'(5);
      default:   return n;
    endcase
  endfunction

  function automatic logic [SelW-1:0] shiftPos(input op_e op, input logic [BitW-1:0] idx);
    return SelW'(int'(idx) - preBits(op));
  endfunction

  function automatic logic isShiftBit(input op_e op, input logic [LenW-1:0] len,
                                      input logic [BitW-1:0] idx);
    int i;
    int pre;
    i   = int'(idx);
    pre = preBits(op);
    return (op == OpShiftIr || op == OpShiftDr) && (i >= pre) && (i < pre + int'(len));
  endfunction

  // Returns {tms, tdi} for bit idx of a command.
  function automatic logic [1:0] bitDrive(input op_e op, input logic [LenW-1:0] len,
                                          input logic [MaxLen-1:0] data,
                                          input logic [BitW-1:0] idx);
    int   i;
    int   n;
    int   pre;
    logic tms;
    logic tdi;
    i   = int'(idx);
    n   = int'(len);
    pre = preBits(op);
    tms = 1'b0;
    tdi = 1'b0;
    case (op)
      OpTlr: tms = (i < 5);
      OpShiftIr, OpShiftDr: begin
        if (i < pre) begin
          tms = (op == OpShiftIr) ? (i < 2) : (i == 0);
        end else if (i < pre + n) begin
          tdi = data[shiftPos(op, idx)];
          tms = (i == pre + n - 1);
        end else begin
          tms = (i == pre + n);
        end
      end
      default: tms = 1'b0;
    endcase
    return {tms, tdi};
  endfunction

  assign cmdOp   = op_e'(cmd_op_i);
  assign lenBad  = (cmdOp == OpShiftIr || cmdOp == OpShiftDr) &&
                   (cmd_len_i == '0 || cmd_len_i > LenW'(MaxLen));
  assign lastBit = totalBits(op_q, len_q) - BitW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      op_q      <= OpTlr;
      len_q     <= '0;
      data_q    <= '0;
      bit_q     <= '0;
      phase_q   <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      trst_q    <= 1'b1;
      rspData_q <= '0;
      rspErr_q  <= 1'b0;
      readyEn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      len_q     <= len_d;
      data_q    <= data_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      trst_q    <= trst_d;
      rspData_q <= rspData_d;
      rspErr_q  <= rspErr_d;
      readyEn_q <= readyEn_d;
    end
  end

  // Each bit is ClkDiv low cycles then ClkDiv high cycles; TDO is captured as TCK rises.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    len_d     = len_q;
    data_d    = data_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    trst_d    = trst_q;
    rspData_d = rspData_q;
    rspErr_d  = rspErr_q;
    readyEn_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_o) begin
          op_d      = cmdOp;
          len_d     = cmd_len_i;
          data_d    = cmd_data_i;
          bit_d     = '0;
          phase_d   = '0;
          rspData_d = '0;
          rspErr_d  = 1'b0;
          if (lenBad) begin
            rspErr_d = 1'b1;
            state_d  = StResp;
          end else if (cmdOp == OpIdle && cmd_len_i == '0) begin
            state_d = StResp;
          end else begin
            state_d         = StRun;
            tck_d           = 1'b0;
            {tms_d, tdi_d}  = bitDrive(cmdOp, cmd_len_i, cmd_data_i, BitW'(0));
            trst_d          = (cmdOp != OpTlr);
          end
        end
      end
      StRun: begin
        if (phase_q == PhW'(2 * ClkDiv - 1)) begin
          tck_d = 1'b0;
          if (bit_q == lastBit) begin
            state_d = StResp;
            trst_d  = 1'b1;
          end else begin
            bit_d          = bit_q + BitW'(1);
            phase_d        = '0;
            {tms_d, tdi_d} = bitDrive(op_q, len_q, data_q, bit_q + BitW'(1));
          end
        end else begin
          phase_d = phase_q + PhW'(1);
          if (phase_q == PhW'(ClkDiv - 1)) begin
            tck_d = 1'b1;
            if (isShiftBit(op_q, len_q, bit_q)) begin
              rspData_d[shiftPos(op_q, bit_q)] = jtag_tdo_i;
            end
          end
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cmd_ready_o  = readyEn_q && (state_q == StIdle);
  assign rsp_valid_o  = (state_q == StResp);
  assign busy_o       = (state_q == StRun);
  assign rsp_data_o   = rspData_q;
  assign rsp_err_o    = rspErr_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_q;

endmodule

// File: tb/tb_jtag_host_seq.sv
// Directed plus randomized bench for jtag_host_seq; a pin monitor records TMS/TDI at each TCK rise
// and plays back a TDO stream, and expected sequences are built from the command rules.
module tb_jtag_host_seq;

  localparam int MaxLen = 64;
  localparam int Div    = 2;
  localparam int LenW   = $clog2(MaxLen + 1);

  logic              clock = 1'b0;
  logic              rst_ni;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op_i;
  logic [LenW-1:0]   cmd_len_i;
  logic [MaxLen-1:0] cmd_data_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [MaxLen-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic              busy_o;
  logic              jtag_tck_o;
  logic              jtag_tms_o;
  logic              jtag_tdi_o;
  logic              jtag_trst_no;
  logic              jtag_tdo_i = 1'b0;

  always #5 clock = ~clock;

  jtag_host_seq #(.MaxLen(MaxLen), .ClkDiv(Div)) dut (
    .clk_i(clock), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_len_i(cmd_len_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .jtag_tck_o(jtag_tck_o), .jtag_tms_o(jtag_tms_o), .jtag_tdi_o(jtag_tdi_o),
    .jtag_trst_no(jtag_trst_no), .jtag_tdo_i(jtag_tdo_i)
  );

  int total = 0;
  int passed = 0;
  int failCount = 0;

  int   riseCount = 0;
  int   riseBase = 0;
  int   highRun = 0;
  int   dutyBad = 0;
  logic tckPrev = 1'b0;
  bit   tmsSeen[$];
  bit   tdiSeen[$];
  bit   trstSeen[$];
  logic [255:0] tdoStream = '0;
  int   qBase = 0;

  logic [255:0] expTms, expTdi;
  logic [63:0]  expRsp;
  logic         expErr;
  int           expBits, expLat;
  logic [63:0]  drModel;

  // TAP-side view of the pins: log TMS/TDI/TRST on each TCK rise, check high time, serve TDO.
  always @(negedge clock) begin
    int idx;
    if (!rst_ni) begin
      highRun = 0;
      tckPrev = 1'b0;
    end else begin
      if (jtag_tck_o && !tckPrev) begin
        tmsSeen.push_back(jtag_tms_o);
        tdiSeen.push_back(jtag_tdi_o);
        trstSeen.push_back(jtag_trst_no);
        riseCount++;
        highRun = 0;
      end
      if (jtag_tck_o) highRun++;
      if (!jtag_tck_o && tckPrev && highRun != Div) dutyBad++;
      tckPrev = jtag_tck_o;
    end
    idx = riseCount - riseBase;
    jtag_tdo_i = (idx >= 0 && idx < 256) ? tdoStream[idx] : 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pin sequence and response derived from the TAP walk for each command type.
  task automatic modelCmd(input int op, input int len, input logic [63:0] data);
    int pre;
    expTms = '0; expTdi = '0; expRsp = '0; expErr = 1'b0; expBits = 0;
    if (op == 0) begin
      expBits = 6;
      for (int i = 0; i < 5; i++) expTms[i] = 1'b1;
    end else if (op == 3) begin
      expBits = len;
    end else if (len < 1 || len > MaxLen) begin
      expErr = 1'b1;
    end else begin
      pre = (op == 1) ? 4 : 3;
      expTms[0] = 1'b1;
      if (op == 1) expTms[1] = 1'b1;
      expTms[pre + len - 1] = 1'b1;
      expTms[pre + len] = 1'b1;
      for (int i = 0; i < len; i++) begin
        expTdi[pre + i] = data[i];
        expRsp[i] = tdoStream[pre + i];
      end
      expBits = pre + len + 2;
    end
    expLat = (expBits == 0) ? 1 : 2 * Div * expBits + 1;
  endtask

  task automatic applyStimulus(input int op, input int len, input logic [63:0] data,
                               output logic [63:0] rdata, output logic rerr,
                               output int lat, output logic busyFirst);
    int guard;
    @(negedge clock);
    guard = 0;
    while (!cmd_ready_o && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'(op);
    cmd_len_i   = LenW'(len);
    cmd_data_i  = data;
    riseBase    = riseCount;
    qBase       = tmsSeen.size();
    @(posedge clock);
    #1 cmd_valid_i = 1'b0;
    lat = 0;
    busyFirst = 1'b0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) busyFirst = busy_o;
    end while (!rsp_valid_o && lat < 5000);
    rdata = rsp_data_o;
    rerr  = rsp_err_o;
  endtask

  task automatic consumeRsp();
    rsp_ready_i = 1'b1;
    @(posedge clock);
    #1 rsp_ready_i = 1'b0;
  endtask

  task automatic checkCmd(input string name, input logic [63:0] rdata, input logic rerr,
                          input int lat, input logic busyFirst);
    logic [255:0] obsTms, obsTdi;
    int n;
    obsTms = '0; obsTdi = '0;
    n = tmsSeen.size() - qBase;
    for (int i = 0; i < n && i < 256; i++) begin
      obsTms[i] = tmsSeen[qBase + i];
      obsTdi[i] = tdiSeen[qBase + i];
    end
    checkOutput({name, "-rises"}, 256'(n), 256'(expBits));
    checkOutput({name, "-tms"}, obsTms, expTms);
    checkOutput({name, "-tdi"}, obsTdi, expTdi);
    checkOutput({name, "-rsp"}, 256'(rdata), 256'(expRsp));
    checkOutput({name, "-err"}, 256'(rerr), 256'(expErr));
    checkOutput({name, "-latency"}, 256'(lat), 256'(expLat));
    checkOutput({name, "-busy"}, 256'(busyFirst), 256'(expLat > 1));
    checkOutput({name, "-tckLowAtResp"}, 256'(jtag_tck_o), 256'(0));
  endtask

  task automatic randomStream();
    for (int w = 0; w < 8; w++) tdoStream[w*32 +: 32] = $urandom;
  endtask

  initial begin
    logic [63:0] rd, data;
    logic        re, bf;
    int          lat, op, len, guard, cnt, riseSnap;

    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_len_i = '0; cmd_data_i = '0;
    rsp_ready_i = 1'b0;
    drModel = {$urandom, $urandom};
    repeat (3) @(negedge clock);
    checkOutput("resetPins", 256'({jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no,
                cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o}), 256'(8'b0101_0000));
    checkOutput("resetRspData", 256'(rsp_data_o), 256'(0));
    rst_ni = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("readyAfterReset", 256'(cmd_ready_o), 256'(1));

    $display("[TB] TLR");
    randomStream();
    data = {$urandom, $urandom};
    modelCmd(0, 0, data);
    applyStimulus(0, 37, data, rd, re, lat, bf);
    checkCmd("tlr", rd, re, lat, bf);
    cnt = 0;
    for (int i = qBase; i < trstSeen.size(); i++) cnt += trstSeen[i];
    checkOutput("tlr-trstLowDuring", 256'(cnt), 256'(0));
    checkOutput("tlr-trstHighAtResp", 256'(jtag_trst_no), 256'(1));
    consumeRsp();

    $display("[TB] SHIFT_IR len 5");
    tdoStream = '0;
    tdoStream[4] = 1'b1;
    modelCmd(1, 5, 64'h15);
    applyStimulus(1, 5, 64'h15, rd, re, lat, bf);
    checkCmd("ir5", rd, re, lat, bf);
    checkOutput("ir5-rspConst", 256'(rd), 256'(64'h1));
    consumeRsp();

    $display("[TB] SHIFT_DR len 64 loopback");
    tdoStream = '0;
    tdoStream[3 +: 64] = drModel;
    modelCmd(2, 64, 64'hDEADBEEF_01234567);
    applyStimulus(2, 64, 64'hDEADBEEF_01234567, rd, re, lat, bf);
    checkCmd("dr64a", rd, re, lat, bf);
    consumeRsp();
    drModel = 64'hDEADBEEF_01234567;
    tdoStream = '0;
    tdoStream[3 +: 64] = drModel;
    data = {$urandom, $urandom};
    modelCmd(2, 64, data);
    applyStimulus(2, 64, data, rd, re, lat, bf);
    checkCmd("dr64b", rd, re, lat, bf);
    checkOutput("dr64b-loopback", 256'(rd), 256'(64'hDEADBEEF_01234567));
    consumeRsp();
    drModel = data;

    $display("[TB] illegal lengths and zero idle");
    randomStream();
    modelCmd(2, 0, 64'hFFFF);
    applyStimulus(2, 0, 64'hFFFF, rd, re, lat, bf);
    checkCmd("drLen0", rd, re, lat, bf);
    consumeRsp();
    modelCmd(2, 65, 64'hFFFF);
    applyStimulus(2, 65, 64'hFFFF, rd, re, lat, bf);
    checkCmd("drLen65", rd, re, lat, bf);
    consumeRsp();
    modelCmd(1, 0, 64'h3);
    applyStimulus(1, 0, 64'h3, rd, re, lat, bf);
    checkCmd("irLen0", rd, re, lat, bf);
    consumeRsp();
    modelCmd(3, 0, 64'h3);
    applyStimulus(3, 0, 64'h3, rd, re, lat, bf);
    checkCmd("idleLen0", rd, re, lat, bf);
    consumeRsp();

    $display("[TB] randomized commands");
    for (int k = 0; k < 6; k++) begin
      op   = $urandom_range(1, 3);
      len  = (op == 3) ? $urandom_range(1, 12) : $urandom_range(1, MaxLen);
      data = {$urandom, $urandom};
      randomStream();
      modelCmd(op, len, data);
      applyStimulus(op, len, data, rd, re, lat, bf);
      checkCmd($sformatf("rand%0d_op%0d_len%0d", k, op, len), rd, re, lat, bf);
      consumeRsp();
    end

    $display("[TB] response backpressure");
    randomStream();
    data = {$urandom, $urandom};
    modelCmd(2, 16, data);
    applyStimulus(2, 16, data, rd, re, lat, bf);
    checkCmd("bp", rd, re, lat, bf);
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (rsp_data_o !== rd || rsp_valid_o !== 1'b1 || cmd_ready_o !== 1'b0) cnt++;
    end
    checkOutput("bp-stableWhileHeld", 256'(cnt), 256'(0));
    rsp_ready_i = 1'b1;
    @(negedge clock);
    rsp_ready_i = 1'b0;
    checkOutput("bp-readyAfterHandshake", 256'(cmd_ready_o), 256'(1));
    modelCmd(3, 3, 64'hFFFF_FFFF);
    applyStimulus(3, 3, 64'hFFFF_FFFF, rd, re, lat, bf);
    checkCmd("idle3", rd, re, lat, bf);
    consumeRsp();
    checkOutput("tckHighTime", 256'(dutyBad), 256'(0));

    $display("[TB] reset mid SHIFT_DR");
    @(negedge clock);
    cmd_valid_i = 1'b1; cmd_op_i = 2'd2; cmd_len_i = LenW'(32); cmd_data_i = {$urandom, $urandom};
    @(posedge clock);
    #1 cmd_valid_i = 1'b0;
    repeat (2 * Div * 10) @(negedge clock);
    guard = 0;
    while (!jtag_tck_o && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("midReset-tmsLowBefore", 256'({jtag_tck_o, jtag_tms_o}), 256'(2'b10));
    #1 rst_ni = 1'b0;
    #1 checkOutput("midReset-pins", 256'({jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no,
                   rsp_valid_o, busy_o, cmd_ready_o}), 256'(7'b0101_000));
    repeat (3) @(negedge clock);
    rst_ni = 1'b1;
    riseSnap = riseCount;
    repeat (3) @(negedge clock);
    checkOutput("midReset-readyAfter", 256'(cmd_ready_o), 256'(1));
    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) cnt++;
    end
    checkOutput("midReset-noStaleRsp", 256'(cnt), 256'(0));
    checkOutput("midReset-noTck", 256'(riseCount - riseSnap), 256'(0));

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jtag_host_seq.md
Name: jtag_host_seq

Overview:
- On-chip JTAG initiator: drives TCK/TMS/TDI/TRST_N and samples TDO. It is the host-side counterpart to the TAP that the JTAG overlay mux exposes on the SPI device DIO pads.
- Used on FPGA targets for self-test and scripted debug-module access without an external probe.
- Takes ready/valid commands (TAP reset, IR shift, DR shift, idle clocks) and returns the captured TDO bits as a response.

Parameters:
- MaxLen, 64: maximum number of shift bits per command.
- ClkDiv, 4: clk_i cycles per TCK half-period; must be >= 1.
- LenW, $clog2(MaxLen+1): width of the length field; derived, not overridable.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready.
- cmd_op_i  in  2  operation: 0 = TLR, 1 = SHIFT_IR, 2 = SHIFT_DR, 3 = IDLE.
- cmd_len_i  in  LenW  number of shift bits, or idle TCK count.
- cmd_data_i  in  MaxLen  TDI data, LSB shifted first.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_data_o  out  MaxLen  captured TDO; bit i = i-th shifted bit.
- rsp_err_o  out  1  illegal length; no TCK was issued.
- busy_o  out  1  command in progress.
- jtag_tck_o  out  1  TCK.
- jtag_tms_o  out  1  TMS.
- jtag_tdi_o  out  1  TDI.
- jtag_trst_no  out  1  TAP reset, active-low.
- jtag_tdo_i  in  1  TDO, already synchronous to clk_i.

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values:
  - tck = 0, tms = 1, tdi = 0, trst_n = 1.
  - cmd_ready = 0 during reset, 1 after.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0, busy = 0.
- FSM states: IDLE, RUN, RESP.
- cmd_ready_o = (state == IDLE). A command is accepted when cmd_valid_i & cmd_ready_o. The accept cycle latches op, len and data, and moves to RUN (or straight to RESP for the error and zero-idle cases).
- TCK bit timing, one bit period = 2*ClkDiv cycles:
  - Low phase: first ClkDiv cycles, tck = 0. TMS/TDI for the bit are updated on the first cycle of the low phase.
  - High phase: next ClkDiv cycles, tck = 1.
  - TDO is sampled on the clk_i edge where tck goes 0 -> 1.
  - The first bit's low phase starts the cycle after accept.
- The host assumes the TAP is in Run-Test/Idle at the start of IR, DR and IDLE commands. Every command ends in Run-Test/Idle.
- TMS sequences (x = shift bits):
  - TLR: 1,1,1,1,1,0 (6 bits). jtag_trst_no = 0 for the whole command, 1 again from RESP.
  - SHIFT_IR: 1,1,0,0, then len bits of x, then 1,0. Total 6+len bits.
  - SHIFT_DR: 1,0,0, then len bits of x, then 1,0. Total 5+len bits.
  - During shift bits, TMS = 0 except on the last shift bit, where TMS = 1 (Exit1).
  - IDLE: len bits with TMS = 0.
- TDI:
  - Shift bit i: tdi = cmd_data[i].
  - Every non-shift bit: tdi = 0.
  - TDO sampled on shift bit i goes to rsp_data[i]. rsp_data bits >= len are 0.
- Completion:
  - The cycle after the last high phase ends: tck = 0, state = RESP, rsp_valid = 1.
  - tms and tdi hold their last values until the next command.
- Response handshake: rsp_valid_o, rsp_data_o and rsp_err_o are stable until rsp_ready_i is seen. On the handshake cycle the block returns to IDLE, and cmd_ready_o = 1 on the next cycle.
- Illegal length: SHIFT_IR or SHIFT_DR with len == 0 or len > MaxLen:
  - No TCK edges are issued.
  - RESP is entered the cycle after accept with rsp_err = 1 and rsp_data = 0.
  - rsp_err = 0 for every other response.
- IDLE with len == 0: RESP the cycle after accept, rsp_err = 0.
- TLR ignores len and data.
- busy_o = (state == RUN).
- Reset mid-operation: all outputs return to reset values immediately. The in-flight command is dropped and no response is produced.
- TCK duty cycle is exactly 50%, with no glitches. tck_o is driven from a flop.

Test Plan:
- Reset, then TLR with ClkDiv = 1:
  - 6 TCK pulses; TMS seen at rising edges = 1,1,1,1,1,0.
  - trst_n = 0 throughout the command.
  - rsp_valid rises 13 cycles after accept; rsp_err = 0.
- SHIFT_IR, len = 5, data = 0x15, TDO model returns 0b00001 on the shift bits:
  - TMS = 1,1,0,0,0,0,0,0,1,1,0 (11 bits).
  - TDI on the 5 shift bits = 1,0,1,0,1.
  - rsp_data = 0x01.
- SHIFT_DR, len = 64, data = 0xDEADBEEF_01234567, bench TAP model as a 64-bit DR looped back:
  - rsp_data equals the previously loaded DR value.
  - Total of 69 TCK periods.
- SHIFT_DR with len = 0, then with len = 65:
  - Each completes with no TCK toggles, rsp_err = 1 and rsp_data = 0, the cycle after accept.
- Backpressure: hold rsp_ready = 0 for 20 cycles after rsp_valid:
  - rsp_data stays stable and cmd_ready stays 0.
  - After the handshake, cmd_ready = 1 on the next cycle.
  - Then IDLE with len = 3 gives 3 TCK pulses with TMS = 0.
- Assert rst_ni mid-way through a SHIFT_DR of len = 32 with ClkDiv = 4:
  - tck = 0, tms = 1 and rsp_valid = 0 immediately.
  - After release, cmd_ready = 1 and no stale response appears.
